// File: rtl/oets_sched_pkg.sv
// Shared types and helpers for the odd-even transposition sort scheduler.
package oets_sched_pkg;

  // Block-level FSM: fill the bank, run the compare phases, stream out.
  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_SORT  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  // Ceiling log2, never below 1 so that index vectors always have a bit.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) begin
      r = r + 1;
    end
    if (r == 0) begin
      r = 1;
    end
    return r;
  endfunction

  // Compare-exchange pairs in one phase: even phases cover (0,1),(2,3)...,
  // odd phases skip both ends and cover (1,2),(3,4)...
  function automatic int pair_count(input int depth, input logic odd_phase);
    return odd_phase ? (depth / 2 - 1) : (depth / 2);
  endfunction

endpackage

// File: rtl/oets_sched_cmp_delay_line.sv
// Valid + pair-index delay line matching the external compare unit latency.
// Only the valid bits carry reset so that in-flight returns are dropped.
module cmp_delay_line #(
  parameter int LATENCY = 1,
  parameter int WIDTH   = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_idx,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_idx
);

  generate
    if (LATENCY == 0) begin : g_thru
      // Combinational compare unit: writeback lands in the issue cycle.
      logic unused_clk_rst;
      assign unused_clk_rst = clk ^ rst;
      assign out_valid      = in_valid;
      assign out_idx        = in_idx;
    end else begin : g_pipe
      logic             valid_reg [LATENCY];
      logic [WIDTH-1:0] idx_reg   [LATENCY];

      // Valid shift chain, cleared by reset to discard pairs in flight.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int i = 0; i < LATENCY; i++) begin
            valid_reg[i] <= 1'b0;
          end
        end else begin
          valid_reg[0] <= in_valid;
          for (int i = 1; i < LATENCY; i++) begin
            valid_reg[i] <= valid_reg[i-1];
          end
        end
      end

      // Index shift chain; qualified by the valids so it needs no reset.
      always_ff @(posedge clk) begin
        idx_reg[0] <= in_idx;
        for (int i = 1; i < LATENCY; i++) begin
          idx_reg[i] <= idx_reg[i-1];
        end
      end

      assign out_valid = valid_reg[LATENCY-1];
      assign out_idx   = idx_reg[LATENCY-1];
    end
  endgenerate

endmodule

// File: rtl/oets_sched.sv
// Odd-even transposition sort scheduler: buffers a block, routes every
// compare-exchange pair through a shared external compare unit, then
// streams the ordered block out. Direction is decided by the compare unit.
module oets_sched
  import oets_sched_pkg::*;
#(
  parameter int DATA_WIDTH  = 64,
  parameter int DEPTH       = 8,
  parameter int CMP_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  m_last,
  output logic [DATA_WIDTH-1:0] trans_data0,
  output logic [DATA_WIDTH-1:0] trans_data1,
  output logic                  trans_valid,
  input  logic [DATA_WIDTH-1:0] rece_data0,
  input  logic [DATA_WIDTH-1:0] rece_data1,
  output logic                  busy
);

  localparam int IDX_W = clog2(DEPTH);
  // Phase cycle counter spans issue slots plus the writeback tail.
  localparam int CYC_W = clog2(DEPTH / 2 + CMP_LATENCY + 1);

  state_t                  state_reg;
  state_t                  state_next;
  logic [IDX_W-1:0]        wr_idx_reg;
  logic [IDX_W-1:0]        rd_idx_reg;
  logic [IDX_W-1:0]        phase_reg;
  logic [CYC_W-1:0]        cyc_reg;
  logic [DATA_WIDTH-1:0]   bank_reg [DEPTH];

  int                      npairs;
  logic                    issue;
  logic                    phase_end;
  logic                    sort_done;
  logic [IDX_W-1:0]        issue_idx;
  logic [IDX_W-1:0]        issue_idx_hi;
  logic                    load_fire;
  logic                    last_load;
  logic                    drain_fire;
  logic                    last_drain;
  logic                    dl_valid;
  logic                    wb_valid;
  logic [IDX_W-1:0]        wb_idx;
  logic [IDX_W-1:0]        wb_idx_hi;

  // Handshake qualifiers for the load and drain streams.
  always_comb begin
    load_fire  = (state_reg == ST_LOAD) && s_valid;
    last_load  = (wr_idx_reg == IDX_W'(DEPTH - 1));
    drain_fire = (state_reg == ST_DRAIN) && m_ready;
    last_drain = (rd_idx_reg == IDX_W'(DEPTH - 1));
  end

  // Phase sequencing: issue one pair per cycle, then wait out the latency
  // so the next phase never reads a word whose writeback is still pending.
  always_comb begin
    npairs       = pair_count(DEPTH, phase_reg[0]);
    issue        = (state_reg == ST_SORT) && (int'(cyc_reg) < npairs);
    phase_end    = (state_reg == ST_SORT) &&
                   (int'(cyc_reg) == npairs + CMP_LATENCY - 1);
    sort_done    = phase_end && (int'(phase_reg) == DEPTH - 1);
    issue_idx    = IDX_W'(2 * int'(cyc_reg) + int'(phase_reg[0]));
    issue_idx_hi = issue_idx + IDX_W'(1);
  end

  cmp_delay_line #(
    .LATENCY (CMP_LATENCY),
    .WIDTH   (IDX_W)
  ) u_delay (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (issue),
    .in_idx    (issue_idx),
    .out_valid (dl_valid),
    .out_idx   (wb_idx)
  );

  // Returned pair is only trusted while sorting.
  always_comb begin
    wb_valid  = dl_valid && (state_reg == ST_SORT);
    wb_idx_hi = wb_idx + IDX_W'(1);
  end

  // Register bank: load port in LOAD, two-word writeback port in SORT.
  // Pairs in a phase are disjoint so the writeback never collides.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (load_fire && (wr_idx_reg == IDX_W'(i))) begin
        bank_reg[i] <= s_data;
      end else if (wb_valid && (wb_idx == IDX_W'(i))) begin
        bank_reg[i] <= rece_data0;
      end else if (wb_valid && (wb_idx_hi == IDX_W'(i))) begin
        bank_reg[i] <= rece_data1;
      end
    end
  end

  // Load write pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_idx_reg <= '0;
    end else if (load_fire) begin
      wr_idx_reg <= last_load ? '0 : wr_idx_reg + IDX_W'(1);
    end
  end

  // Phase cycle and phase number counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cyc_reg   <= '0;
      phase_reg <= '0;
    end else begin
      if (state_reg == ST_SORT) begin
        cyc_reg <= phase_end ? '0 : cyc_reg + CYC_W'(1);
      end else begin
        cyc_reg <= '0;
      end
      if (phase_end) begin
        phase_reg <= sort_done ? '0 : phase_reg + IDX_W'(1);
      end
    end
  end

  // Drain read pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_idx_reg <= '0;
    end else if (drain_fire) begin
      rd_idx_reg <= last_drain ? '0 : rd_idx_reg + IDX_W'(1);
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_LOAD;
    end else begin
      state_reg <= state_next;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_LOAD:  if (load_fire && last_load)   state_next = ST_SORT;
      ST_SORT:  if (sort_done)                state_next = ST_DRAIN;
      ST_DRAIN: if (drain_fire && last_drain) state_next = ST_LOAD;
      default:                                state_next = ST_LOAD;
    endcase
  end

  // FSM outputs; every data output is forced to zero when not in use.
  always_comb begin
    s_ready     = 1'b0;
    busy        = 1'b1;
    m_valid     = 1'b0;
    m_last      = 1'b0;
    m_data      = '0;
    trans_valid = 1'b0;
    trans_data0 = '0;
    trans_data1 = '0;
    case (state_reg)
      ST_LOAD: begin
        s_ready = 1'b1;
        busy    = 1'b0;
      end
      ST_SORT: begin
        if (issue) begin
          trans_valid = 1'b1;
          trans_data0 = bank_reg[issue_idx];
          trans_data1 = bank_reg[issue_idx_hi];
        end
      end
      ST_DRAIN: begin
        m_valid = 1'b1;
        m_data  = bank_reg[rd_idx_reg];
        m_last  = last_drain;
      end
      default: begin
        busy = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_oets_sched.sv
// Bench for oets_sched: three instances (latency 1, 0, 4) share stimulus,
// each with an ascending compare model; a negedge monitor drains a request
// queue and an expected-output scoreboard.
module tb_oets_sched;

  localparam int DW = 64;
  localparam int NI = 3;

  typedef logic [DW-1:0] blk_t [8];
  typedef struct { logic [DW-1:0] data; logic last; } exp_t;
  typedef enum int { K_CLEAR, K_PAIR, K_STAT, K_IDLE, K_LEN, K_DRAINED, K_TIMEOUT } kind_t;
  typedef struct { kind_t kind; int inst; logic [DW-1:0] a; logic [DW-1:0] b; string name; } req_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic s_valid = 1'b0;
  logic [DW-1:0] s_data = '0;
  logic m_ready = 1'b0;

  logic [NI-1:0]         s_ready_a, m_valid_a, m_last_a, busy_a, tv_a;
  logic [NI-1:0][DW-1:0] m_data_a, t0_a, t1_a, r0_a, r1_a;

  exp_t exp_q[$];
  req_t req_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Expected SORT lengths: L=1: 4*5+4*4, L=0: 4*4+4*3, L=4: 4*8+4*7.
  int exp_len [NI] = '{36, 28, 60};

  always #5 clk = ~clk;

  generate
    for (genvar gi = 0; gi < NI; gi++) begin : g_inst
      localparam int L = (gi == 0) ? 1 : ((gi == 1) ? 0 : 4);
      logic [DW-1:0] lo, hi;
      assign lo = (t0_a[gi] < t1_a[gi]) ? t0_a[gi] : t1_a[gi];
      assign hi = (t0_a[gi] < t1_a[gi]) ? t1_a[gi] : t0_a[gi];
      if (L == 0) begin : g_comb
        assign r0_a[gi] = lo;
        assign r1_a[gi] = hi;
      end else begin : g_pipe
        logic [DW-1:0] p0 [L];
        logic [DW-1:0] p1 [L];
        always @(posedge clk) begin
          p0[0] <= lo;
          p1[0] <= hi;
          for (int j = 1; j < L; j++) begin
            p0[j] <= p0[j-1];
            p1[j] <= p1[j-1];
          end
        end
        assign r0_a[gi] = p0[L-1];
        assign r1_a[gi] = p1[L-1];
      end
      oets_sched #(.DATA_WIDTH(DW), .DEPTH(8), .CMP_LATENCY(L)) u_dut (
        .clk(clk), .rst(rst),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready_a[gi]),
        .m_data(m_data_a[gi]), .m_valid(m_valid_a[gi]), .m_ready(m_ready), .m_last(m_last_a[gi]),
        .trans_data0(t0_a[gi]), .trans_data1(t1_a[gi]), .trans_valid(tv_a[gi]),
        .rece_data0(r0_a[gi]), .rece_data1(r1_a[gi]), .busy(busy_a[gi])
      );
    end
  endgenerate

  // ---------------- monitor ----------------
  int            rd_ptr     [NI] = '{default: 0};
  logic          stall_prev [NI] = '{default: 1'b0};
  logic [DW-1:0] held_d     [NI] = '{default: '0};
  logic          held_l     [NI] = '{default: 1'b0};
  int            sort_cnt   [NI] = '{default: 0};
  int            tv_cnt     [NI] = '{default: 0};

  always @(negedge clk) begin
    req_t r;
    logic [3:0] st;
    while (req_q.size() > 0) begin
      r = req_q.pop_front();
      case (r.kind)
        K_CLEAR: begin
          sort_cnt[r.inst] = 0;
          tv_cnt[r.inst]   = 0;
        end
        K_PAIR: begin
          n_cmp++;
          if (tv_a[r.inst] !== 1'b1 || t0_a[r.inst] !== r.a || t1_a[r.inst] !== r.b) begin
            n_bad++;
            $display("FAIL %s inst%0d: got tv=%b %h/%h expected tv=1 %h/%h", r.name, r.inst,
                     tv_a[r.inst], t0_a[r.inst], t1_a[r.inst], r.a, r.b);
          end
        end
        K_STAT: begin
          n_cmp++;
          st = {s_ready_a[r.inst], busy_a[r.inst], tv_a[r.inst], m_valid_a[r.inst]};
          if (st !== r.a[3:0]) begin
            n_bad++;
            $display("FAIL %s inst%0d: got {s_ready,busy,tv,m_valid}=%b expected %b", r.name, r.inst, st, r.a[3:0]);
          end
        end
        K_IDLE: begin
          n_cmp++;
          if ({s_ready_a[r.inst], busy_a[r.inst], tv_a[r.inst], m_valid_a[r.inst], m_last_a[r.inst]} !== 5'b10000 ||
              m_data_a[r.inst] !== '0 || t0_a[r.inst] !== '0 || t1_a[r.inst] !== '0) begin
            n_bad++;
            $display("FAIL %s inst%0d: got rdy=%b busy=%b tv=%b mv=%b ml=%b md=%h t0=%h t1=%h expected 1,0,0,0,0 and zero data",
                     r.name, r.inst, s_ready_a[r.inst], busy_a[r.inst], tv_a[r.inst], m_valid_a[r.inst],
                     m_last_a[r.inst], m_data_a[r.inst], t0_a[r.inst], t1_a[r.inst]);
          end
        end
        K_LEN: begin
          n_cmp++;
          if (sort_cnt[r.inst] != int'(r.a) || tv_cnt[r.inst] != int'(r.b)) begin
            n_bad++;
            $display("FAIL %s inst%0d: got sort=%0d issues=%0d expected sort=%0d issues=%0d", r.name, r.inst,
                     sort_cnt[r.inst], tv_cnt[r.inst], r.a, r.b);
          end
        end
        K_DRAINED: begin
          n_cmp++;
          if (rd_ptr[r.inst] != exp_q.size()) begin
            n_bad++;
            $display("FAIL %s inst%0d: got %0d words expected %0d", r.name, r.inst, rd_ptr[r.inst], exp_q.size());
          end
        end
        default: begin
          n_cmp++;
          n_bad++;
          $display("FAIL %s inst%0d: got timeout expected event", r.name, r.inst);
        end
      endcase
    end
    for (int g = 0; g < NI; g++) begin
      if (stall_prev[g]) begin
        n_cmp++;
        if (m_data_a[g] !== held_d[g] || m_last_a[g] !== held_l[g]) begin
          n_bad++;
          $display("FAIL stall_hold inst%0d: got %h/%b expected %h/%b", g, m_data_a[g], m_last_a[g], held_d[g], held_l[g]);
        end
      end
      if (m_valid_a[g] && m_ready) begin
        n_cmp++;
        if (rd_ptr[g] >= exp_q.size()) begin
          n_bad++;
          $display("FAIL out_word inst%0d: got %h expected no word", g, m_data_a[g]);
        end else if (m_data_a[g] !== exp_q[rd_ptr[g]].data || m_last_a[g] !== exp_q[rd_ptr[g]].last) begin
          n_bad++;
          $display("FAIL out_word inst%0d #%0d: got %h last=%b expected %h last=%b", g, rd_ptr[g],
                   m_data_a[g], m_last_a[g], exp_q[rd_ptr[g]].data, exp_q[rd_ptr[g]].last);
        end
        rd_ptr[g]++;
      end
      stall_prev[g] = m_valid_a[g] && !m_ready;
      held_d[g]     = m_data_a[g];
      held_l[g]     = m_last_a[g];
      if (busy_a[g] && !m_valid_a[g]) sort_cnt[g]++;
      if (tv_a[g]) tv_cnt[g]++;
    end
  end

  // ---------------- stimulus ----------------
  task automatic push(input kind_t k, input int inst, input logic [DW-1:0] a,
                      input logic [DW-1:0] b, input string name);
    req_t r;
    r.kind = k; r.inst = inst; r.a = a; r.b = b; r.name = name;
    req_q.push_back(r);
  endtask

  task automatic push_all(input kind_t k, input logic [DW-1:0] a, input logic [DW-1:0] b, input string name);
    for (int g = 0; g < NI; g++) push(k, g, a, b, name);
  endtask

  // Called at posedge+1 with every instance in LOAD.
  task automatic load_block(input blk_t w, input blk_t srt, input bit expect_out);
    exp_t e;
    for (int j = 0; j < 8; j++) begin
      s_valid = 1'b1;
      s_data  = w[j];
      @(posedge clk); #1;
    end
    s_valid = 1'b0;
    s_data  = '0;
    if (expect_out) begin
      for (int j = 0; j < 8; j++) begin
        e.data = srt[j];
        e.last = (j == 7);
        exp_q.push_back(e);
      end
    end
    push_all(K_CLEAR, '0, '0, "clear");
    push_all(K_PAIR, w[0], w[1], "first_pair");
  endtask

  task automatic wait_sorted();
    int guard = 0;
    @(negedge clk);
    while (!(&m_valid_a) && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 200) push_all(K_TIMEOUT, '0, '0, "sort_timeout");
    for (int g = 0; g < NI; g++) push(K_LEN, g, DW'(exp_len[g]), DW'(28), "sort_len");
    @(posedge clk); #1;
  endtask

  task automatic drain_block(input logic [15:0] pat, input bit hold_s, input logic [DW-1:0] first_w);
    int got = 0;
    int cyc = 0;
    if (hold_s) begin
      s_valid = 1'b1;
      s_data  = first_w;
    end
    while (got < 8 && cyc < 300) begin
      m_ready = pat[cyc % 16];
      if (m_ready && m_valid_a[0]) begin
        if (got == 7) push_all(K_STAT, DW'(4'b0101), '0, "last_drain_cycle");
        got++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    m_ready = 1'b0;
    if (got < 8) push_all(K_TIMEOUT, '0, '0, "drain_timeout");
    push_all(K_STAT, DW'(4'b1000), '0, "back_in_load");
  endtask

  blk_t a_in  = '{7, 3, 9, 1, 8, 2, 6, 4};
  blk_t a_out = '{1, 2, 3, 4, 6, 7, 8, 9};
  blk_t b_in  = '{9, 8, 7, 6, 5, 4, 3, 2};
  blk_t b_out = '{2, 3, 4, 5, 6, 7, 8, 9};
  blk_t c_in  = '{11, 12, 13, 14, 15, 16, 17, 18};
  blk_t d_in  = '{5, 5, 5, 1, 1, 5, 1, 5};
  blk_t d_out = '{1, 1, 1, 5, 5, 5, 5, 5};
  blk_t e_in  = '{64'hFEDC_BA98_7654_3210, 64'h0, 64'h8000_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF,
                  64'h1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0123_4567_89AB_CDEF, 64'h2};
  blk_t e_out = '{64'h0, 64'h1, 64'h2, 64'h0123_4567_89AB_CDEF, 64'h7FFF_FFFF_FFFF_FFFF,
                  64'h8000_0000_0000_0000, 64'hFEDC_BA98_7654_3210, 64'hFFFF_FFFF_FFFF_FFFF};

  initial begin
    // Reset values, during and after reset.
    repeat (2) @(posedge clk);
    #1;
    push_all(K_IDLE, '0, '0, "reset_idle");
    @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
    push_all(K_IDLE, '0, '0, "post_reset_idle");
    @(negedge clk);
    @(posedge clk); #1;

    // Block A, then next block's first word held valid across the boundary.
    load_block(a_in, a_out, 1'b1);
    wait_sorted();
    drain_block(16'hFFFF, 1'b1, b_in[0]);

    // Block B: reverse order with a stall pattern on m_ready.
    load_block(b_in, b_out, 1'b1);
    wait_sorted();
    drain_block(16'b0110_1001_1101_0011, 1'b0, '0);

    // Block C: reset mid-SORT (latency 4: phase 3, two pairs in flight).
    load_block(c_in, c_in, 1'b0);
    repeat (25) @(posedge clk);
    #1;
    push_all(K_STAT, DW'(4'b0110), '0, "pre_reset_issue");
    @(negedge clk);
    #1;
    rst = 1'b1;
    push_all(K_IDLE, '0, '0, "mid_sort_reset");
    @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
    push_all(K_IDLE, '0, '0, "after_mid_reset");
    @(negedge clk);
    @(posedge clk); #1;

    // Block D: duplicates after the aborted block.
    load_block(d_in, d_out, 1'b1);
    wait_sorted();
    drain_block(16'hFFFF, 1'b0, '0);

    // Block E: full-width values.
    load_block(e_in, e_out, 1'b1);
    wait_sorted();
    drain_block(16'b1010_0101_1100_0011, 1'b0, '0);

    push_all(K_DRAINED, '0, '0, "all_words_out");
    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
